// File: rtl/serial_pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx_pkg
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default word / word-counter widths.
// -----------------------------------------------------------------------------
package serial_pattern_tx_pkg;

    localparam int DEFAULT_WIDTH = 4;   // bits per transmitted word
    localparam int DEFAULT_CNT_W = 8;   // width of the transmitted-word counter

    typedef enum logic {
        IDLE  = 1'b0,   // nothing on the line, hold register empty
        SHIFT = 1'b1    // a word is being serialised
    } tx_state_e;

endpackage

// File: rtl/serial_pattern_tx_shift_reg.sv
// -----------------------------------------------------------------------------
// tx_shift_reg
// MSB-first parallel-to-serial shifter with its bit counter.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (clears shifter and counter)
//   load      : load load_data into the shifter, counter back to 0
//   load_data : word to serialise
//   shift     : advance to the next lower bit (zero fill)
//   bit_out   : current serial bit (MSB of the shifter, a register bit)
//   last_bit  : the current bit is the LSB of the word
// -----------------------------------------------------------------------------
module tx_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             bit_out,
    output logic             last_bit
);

    localparam int BW = $clog2(WIDTH);

    logic [WIDTH-1:0] sh_q;
    logic [BW-1:0]    cnt_q;

    // Zero fill means that after the final shift of a word the register is
    // all zeros, so bit_out is naturally 0 while the transmitter is idle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every register so all flops
        // update together from the values present before the edge.
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sh_q  <= load_data;
            cnt_q <= '0;
        end else if (shift) begin
            sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            cnt_q <= last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    assign bit_out  = sh_q[WIDTH-1];
    assign last_bit = (cnt_q == BW'(WIDTH - 1));

endmodule

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
// Serialises WIDTH-bit words MSB first, one bit per clock, with a one-entry
// hold register so consecutive words leave the block without an idle gap.
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   din         : parallel word, sampled only on an accept edge
//   din_valid   : din holds a word to send
//   din_ready   : registered; high when the hold register is free
//   out         : serial bit stream (0 while idle)
//   out_valid   : out carries a data bit
//   frame_start : out carries the MSB of a word
//   word_cnt    : number of words fully transmitted (wraps)
// -----------------------------------------------------------------------------
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic [CNT_W-1:0] word_cnt
);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             ready_q;
    logic             out_valid_q, out_valid_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] word_cnt_q;
    logic             word_done;

    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             shift;
    logic             last_bit;

    assign accept = din_valid && ready_q;

    tx_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .shift     (shift),
        .bit_out   (out),
        .last_bit  (last_bit)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case leaves one unassigned and infers a latch.
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        out_valid_d = 1'b0;
        frame_d     = 1'b0;
        load        = 1'b0;
        load_data   = din;
        shift       = 1'b0;
        word_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load        = 1'b1;
                    state_d     = SHIFT;
                    out_valid_d = 1'b1;
                    frame_d     = 1'b1;
                end
            end
            SHIFT: begin
                out_valid_d = 1'b1;
                if (last_bit) begin
                    word_done = 1'b1;
                    if (hold_full_q) begin
                        // ready_q is low here, so no accept can collide
                        // with draining the hold register.
                        load        = 1'b1;
                        load_data   = hold_q;
                        hold_full_d = 1'b0;
                        frame_d     = 1'b1;
                    end else if (accept) begin
                        load    = 1'b1;
                        frame_d = 1'b1;
                    end else begin
                        // Final zero-fill shift leaves the line at 0.
                        shift       = 1'b1;
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end else begin
                    shift = 1'b1;
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            out_valid_q <= 1'b0;
            frame_q     <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            out_valid_q <= out_valid_d;
            frame_q     <= frame_d;
            word_cnt_q  <= word_cnt_q + CNT_W'(word_done);
        end
    end

    // NOTE: the hold data register has no reset; hold_full qualifies it, and
    // clearing hold_full on reset is what discards a pending word.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign din_ready   = ready_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_tx
// Directed self-checking bench for serial_pattern_tx (WIDTH=4, CNT_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       out;
    logic       out_valid;
    logic       frame_start;
    logic [7:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    serial_pattern_tx #(.WIDTH(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .out         (out),
        .out_valid   (out_valid),
        .frame_start (frame_start),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offer n words back to back (din_valid held high while words remain),
    // collect the serial stream and compare it against the concatenated words.
    task automatic run_words(input string tag, input int n,
                             input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
        logic [3:0]  w [3];
        logic [11:0] exp_bits, exp_mask, got_bits, got_mask;
        logic [3:0]  win;
        logic [7:0]  cnt0;
        logic        ready_seen, saw_stall, done;
        int          idx, nbits, exp_hits, got_hits;
        w[0] = w0; w[1] = w1; w[2] = w2;
        exp_bits = '0; exp_mask = '0;
        for (int i = 0; i < n; i++) begin
            exp_bits = {exp_bits[7:0], w[i]};
            exp_mask = {exp_mask[7:0], 4'b1000};
        end
        exp_hits = 0;
        for (int i = 4*n - 1; i >= 3; i--)
            if (exp_bits[i -: 4] == 4'b1011) exp_hits++;
        cnt0 = word_cnt; idx = 0; nbits = 0; got_bits = '0; got_mask = '0;
        got_hits = 0; win = '0; saw_stall = 1'b0; done = 1'b0;
        din = w[0]; din_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            ready_seen = din_ready;
            @(negedge clk);
            if (din_valid && ready_seen) begin
                idx++;
                if (idx < n) din = w[idx];
                else begin din_valid = 1'b0; din = '0; end
            end
            if (din_valid && !din_ready) saw_stall = 1'b1;
            if (out_valid) begin
                got_bits = {got_bits[10:0], out};
                got_mask = {got_mask[10:0], frame_start};
                win      = {win[2:0], out};
                if (win == 4'b1011) got_hits++;
                nbits++;
            end else if (nbits > 0) begin
                done = 1'b1;
            end
        end
        din_valid = 1'b0;
        check({tag, "_finished"}, 32'(done), 32'd1);
        check({tag, "_nbits"}, nbits, 4*n);
        check({tag, "_stream"}, 32'(got_bits), 32'(exp_bits));
        check({tag, "_frame_mask"}, 32'(got_mask), 32'(exp_mask));
        check({tag, "_det_hits"}, got_hits, exp_hits);
        check({tag, "_word_cnt"}, 32'(word_cnt), 32'(8'(cnt0 + n)));
        if (n == 3) check({tag, "_ready_stall"}, 32'(saw_stall), 32'd1);
    endtask

    initial begin
        logic [3:0] pat;
        logic [7:0] prev;
        logic       ready_seen, done, saw255;
        int         acc, nbits, bad, badstep;

        // ---- reset ----
        rst = 1'b1; din = 4'b1111; din_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame", 32'(frame_start), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_idle_valid", 32'(out_valid), 32'd0);

        // ---- single word 1011, cycle by cycle; din changes after accept ----
        pat = 4'b1011;
        din = pat; din_valid = 1'b1;
        @(negedge clk);                     // edge N accepted
        din = 4'b0100; din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("single_out%0d", k), 32'(out), 32'(pat[3-k]));
            check($sformatf("single_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("single_frame%0d", k), 32'(frame_start), 32'(k == 0));
            if (k == 3) check("single_cnt_before", 32'(word_cnt), 32'd0);
            @(negedge clk);
        end
        check("single_idle_valid", 32'(out_valid), 32'd0);
        check("single_idle_out", 32'(out), 32'd0);
        check("single_word_cnt", 32'(word_cnt), 32'd1);
        check("single_ready", 32'(din_ready), 32'd1);

        // ---- back-to-back, three words with stall, detector chain ----
        run_words("b2b", 2, 4'b1011, 4'b0110, 4'b0000);
        run_words("three", 3, 4'b1011, 4'b0110, 4'b1100);
        run_words("det", 2, 4'b1011, 4'b1011, 4'b0000);

        // ---- reset during bit 2, with an accept offered during reset ----
        din = 4'b1011; din_valid = 1'b1;
        @(negedge clk);                     // accepted, bit 1 on the line
        din_valid = 1'b0;
        @(negedge clk);                     // bit 2 on the line
        check("mid_bit2", 32'(out), 32'd0);
        rst = 1'b1; din = 4'b1101; din_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        check("mid_after_valid", 32'(out_valid), 32'd0);
        check("mid_after_ready", 32'(din_ready), 32'd1);
        run_words("after_rst", 1, 4'b1101, 4'b0000, 4'b0000);

        // ---- 256 words: word_cnt reaches 255 then wraps ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pat = 4'b1011; din = pat; din_valid = 1'b1;
        acc = 0; nbits = 0; bad = 0; badstep = 0; saw255 = 1'b0; done = 1'b0;
        prev = word_cnt;
        for (int cyc = 0; cyc < 1200 && !done; cyc++) begin
            ready_seen = din_ready;
            @(negedge clk);
            if (din_valid && ready_seen) begin
                acc++;
                if (acc == 256) din_valid = 1'b0;
            end
            if (word_cnt != prev) begin
                if (word_cnt != 8'(prev + 1)) badstep++;
                if (word_cnt == 8'd255) saw255 = 1'b1;
                prev = word_cnt;
            end
            if (out_valid) begin
                if (out !== pat[3 - (nbits % 4)]) bad++;
                nbits++;
            end else if (nbits > 0) begin
                done = 1'b1;
            end
        end
        din_valid = 1'b0;
        check("wrap_finished", 32'(done), 32'd1);
        check("wrap_nbits", nbits, 1024);
        check("wrap_bit_errors", bad, 0);
        check("wrap_bad_steps", badstep, 0);
        check("wrap_saw_255", 32'(saw255), 32'd1);
        check("wrap_word_cnt", 32'(word_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits per word, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: width of the word counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port din, input, WIDTH: parallel word, MSB transmitted first.
REQ-006 SHALL have port din_valid, input, 1: din holds a word to send.
REQ-007 SHALL have port din_ready, output, 1: block can accept a word this cycle.
REQ-008 SHALL have port out, output, 1: serial bit stream, one bit per clk, to the 1011 detector's in.
REQ-009 SHALL have port out_valid, output, 1: out carries a data bit.
REQ-010 SHALL have port frame_start, output, 1: out carries the MSB of a word.
REQ-011 SHALL have port word_cnt, output, CNT_W: number of words fully transmitted.

Function
REQ-012 SHALL accept a word on a rising edge where din_valid and din_ready are both 1; no other edge accepts.
REQ-013 SHALL implement states IDLE and SHIFT, plus a 1-entry hold register with a full flag.
REQ-014 SHALL drive din_ready = not hold_full, registered; in IDLE, hold is always empty.
REQ-015 IDLE plus accept: word loads straight into the shifter; state becomes SHIFT; the MSB appears on out in the cycle after the accept edge.
REQ-016 SHIFT plus accept: word goes to the hold register and hold_full sets.
REQ-017 The bit counter SHALL run 0..WIDTH-1; each edge in SHIFT advances out to the next lower bit.
REQ-018 On the edge ending the last bit with hold_full=1: hold SHALL move to the shifter; hold_full clears; the counter returns to 0; no idle gap.
REQ-019 On the edge ending the last bit with hold_full=0 and no accept: state SHALL return to IDLE.
REQ-020 A word accepted on the same edge that ends the last bit (hold empty) SHALL load directly into the shifter, gapless.
REQ-021 Last-bit edge with hold_full=1: din_ready is 0 on that edge, so no accept occurs; hold is free from the next cycle.
REQ-022 In IDLE, out SHALL be 0 and out_valid SHALL be 0; in SHIFT, out_valid SHALL be 1.
REQ-023 frame_start SHALL be 1 exactly in the first bit cycle of each word, else 0.
REQ-024 word_cnt SHALL increment by 1 on each last-bit edge, wrapping from 2^CNT_W-1 to 0.
REQ-025 din SHALL be sampled only on an accept edge; later changes to din SHALL not affect a word in flight.

Reset
REQ-026 rst=1 at an edge SHALL force these values, overriding an accept on the same edge:
- state = IDLE
- hold_full = 0, bit counter = 0, shifter = 0
- word_cnt = 0, out = 0, out_valid = 0, frame_start = 0
- din_ready = 1 from the first cycle after the release edge
REQ-027 Reset mid-word SHALL discard the shifter and hold contents; no partial bits are emitted after reset.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, SHIFT) and the default WIDTH and CNT_W constants.
REQ-029 The shifter and bit counter SHALL be one sub-module, tx_shift_reg: ports load, load_data, shift, bit_out, last_bit.
REQ-030 All outputs SHALL be driven from registers; no combinational path from din or din_valid to any output.

Verification
REQ-031 Single word 4'b1011 accepted at edge N -> out = 1,0,1,1 in cycles N+1..N+4, with:
- out_valid = 1 for those 4 cycles
- frame_start = 1 in cycle N+1 only
- word_cnt = 1 after edge N+4
REQ-032 Back-to-back 4'b1011 then 4'b0110, din_valid held high -> out = 1,0,1,1,0,1,1,0 contiguous, frame_start in bit cycles 1 and 5, word_cnt = 2.
REQ-033 Three words offered continuously -> din_ready falls to 0 once hold is full, third word held until hold drains, no word lost or duplicated, 12 contiguous bits out.
REQ-034 rst asserted during bit 2 of 4'b1011 -> out = 0, out_valid = 0, word_cnt = 0 next cycle; next word starts with frame_start and its MSB.
REQ-035 256 words of 4'b1011 with CNT_W=8 -> word_cnt reaches 255, then wraps to 0 on the 256th last bit.
REQ-036 Chained into the 1011 detector with words 1011, 1011 -> detector out asserts once per emitted 1011 occurrence, checked by a scoreboard.
